// File: rtl/code_memory_controller.sv
// Code-memory controller: decodes the bus address onto N code blocks; faults unmapped or protected-write accesses.
// Latency: fault 1 cycle, write 2, read MEM_LATENCY+2 (prefetch hit 1); optional CODEMEM_PREFETCH_EN buffer.
// Backpressure: oReady only in IDLE, so a request is held by the master until the previous access has responded.
module code_memory_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_REGIONS = 3,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE  = {32'h8000_0000, 32'h0040_0000, 32'h0000_0000},
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_LIMIT = {32'h8000_1FFF, 32'h0040_3FFF, 32'h0000_07FF},
  parameter logic [N_REGIONS-1:0] REGION_WRITABLE = 3'b110,
  parameter int MEM_LATENCY = 1
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic                          iReq,
  input  logic                          iWe,
  input  logic [DATA_W/8-1:0]           iBE,
  input  logic [ADDR_W-1:0]             iAddr,
  input  logic [DATA_W-1:0]             iWData,
  output logic                          oReady,
  output logic                          oValid,
  output logic [DATA_W-1:0]             oRData,
  output logic                          oFault,
  output logic [N_REGIONS-1:0]          oMemSel,
  output logic [ADDR_W-3:0]             oMemAddr,
  output logic                          oMemWren,
  output logic [DATA_W/8-1:0]           oMemBE,
  output logic [DATA_W-1:0]             oMemWData,
  input  logic [N_REGIONS*DATA_W-1:0]   iMemRData
);
  localparam int RW = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
  localparam int WW = ADDR_W - 2;
  localparam int BW = DATA_W / 8;

`ifdef CODEMEM_PREFETCH_EN
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, PREFETCH} state_t;
`else
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP} state_t;
`endif

  state_t            state, nextState;
  logic [RW-1:0]     regIdx, hitIdx;
  logic [WW-1:0]     wordLat, latBaseW;
  logic              weLat, faultLat, hit, reqFault, memActive;
  logic [BW-1:0]     beLat;
  logic [DATA_W-1:0] wdLat, rdataLat, memQ;
  logic [2:0]        cnt;

  // Reverse scan so the lowest-indexed matching region wins on overlap.
  always_comb begin
    hit = 1'b0;
    hitIdx = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (iAddr >= REGION_BASE[i*ADDR_W +: ADDR_W] && iAddr <= REGION_LIMIT[i*ADDR_W +: ADDR_W]) begin
        hit = 1'b1;
        hitIdx = RW'(i);
      end
    end
  end

  assign reqFault = !hit || (iWe && !REGION_WRITABLE[hitIdx]);
  assign latBaseW = REGION_BASE[int'(regIdx)*ADDR_W + 2 +: WW];
  assign memQ     = iMemRData[int'(regIdx)*DATA_W +: DATA_W];

`ifdef CODEMEM_PREFETCH_EN
  logic              pfVld, pfActive, pfHit, pfGo;
  logic [WW-1:0]     pfTag, nextWord, latLimitW;
  logic [DATA_W-1:0] pfData;

  assign latLimitW = REGION_LIMIT[int'(regIdx)*ADDR_W + 2 +: WW];
  assign nextWord  = wordLat + 1'b1;
  assign pfHit     = pfVld && !iWe && (pfTag == iAddr[ADDR_W-1:2]);
  // Only a successful read chains a prefetch, and only while the next word stays inside its region.
  assign pfGo      = !weLat && !faultLat && (nextWord != '0) && (nextWord <= latLimitW);
`endif

  always_ff @(posedge iCLK) begin
    if (!iRST) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (iReq) begin
          if (reqFault) nextState = RESP;
`ifdef CODEMEM_PREFETCH_EN
          else if (pfHit) nextState = RESP;
`endif
          else nextState = ISSUE;
        end
      end
      ISSUE: nextState = weLat ? RESP : WAIT;
      WAIT: begin
        if (cnt == 3'd1) begin
`ifdef CODEMEM_PREFETCH_EN
          nextState = pfActive ? IDLE : RESP;
`else
          nextState = RESP;
`endif
        end
      end
`ifdef CODEMEM_PREFETCH_EN
      RESP:     nextState = pfGo ? PREFETCH : IDLE;
      PREFETCH: nextState = WAIT;
`else
      RESP:     nextState = IDLE;
`endif
      default:  nextState = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      regIdx <= '0; wordLat <= '0; weLat <= 1'b0; faultLat <= 1'b0;
      beLat <= '0; wdLat <= '0; rdataLat <= '0; cnt <= '0;
`ifdef CODEMEM_PREFETCH_EN
      pfVld <= 1'b0; pfActive <= 1'b0; pfTag <= '0; pfData <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (iReq) begin
            regIdx   <= hitIdx;
            wordLat  <= iAddr[ADDR_W-1:2];
            weLat    <= iWe;
            beLat    <= iBE;
            wdLat    <= iWData;
            faultLat <= reqFault;
            rdataLat <= '0;
`ifdef CODEMEM_PREFETCH_EN
            if (iWe) pfVld <= 1'b0;
            else if (!reqFault && pfHit) rdataLat <= pfData;
`endif
          end
        end
        ISSUE: cnt <= 3'(MEM_LATENCY);
        WAIT: begin
          if (cnt == 3'd1) begin
`ifdef CODEMEM_PREFETCH_EN
            if (pfActive) begin
              pfData   <= memQ;
              pfTag    <= wordLat;
              pfVld    <= 1'b1;
              pfActive <= 1'b0;
            end else begin
              rdataLat <= memQ;
            end
`else
            rdataLat <= memQ;
`endif
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
`ifdef CODEMEM_PREFETCH_EN
        RESP: if (pfGo) wordLat <= nextWord;
        PREFETCH: begin
          cnt      <= 3'(MEM_LATENCY);
          pfActive <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
`ifdef CODEMEM_PREFETCH_EN
    memActive = (state == ISSUE) || (state == WAIT) || (state == PREFETCH);
`else
    memActive = (state == ISSUE) || (state == WAIT);
`endif
    oReady    = (state == IDLE);
    oValid    = (state == RESP);
    oFault    = (state == RESP) && faultLat;
    oRData    = (state == RESP) ? rdataLat : '0;
    oMemSel   = memActive ? (N_REGIONS'(1) << regIdx) : '0;
    oMemAddr  = memActive ? (wordLat - latBaseW) : '0;
    oMemWren  = (state == ISSUE) && weLat;
    oMemBE    = oMemWren ? beLat : '0;
    oMemWData = oMemWren ? wdLat : '0;
  end
endmodule

// File: tb/tb_code_memory_controller.sv
// Bench for code_memory_controller: vector table driven through a request task, responses matched by a scoreboard.
// Block memories are modelled as gated pipelines whose depth equals the instance latency.
module tb_code_memory_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN, req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        ready, valid, fault, wren;
  logic [31:0] rdata, memWData;
  logic [2:0]  memSel;
  logic [29:0] memAddr;
  logic [3:0]  memBE;
  logic [95:0] memQ;

  logic        req3, ready3, valid3, fault3, wren3;
  logic [31:0] addr3, rdata3, wd3;
  logic [2:0]  sel3;
  logic [29:0] maddr3;
  logic [3:0]  be3;
  logic [95:0] q3a, q3b, q3c;

`ifdef CODEMEM_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  code_memory_controller #(.MEM_LATENCY(1)) dut (
    .iCLK(clk), .iRST(rstN), .iReq(req), .iWe(we), .iBE(be), .iAddr(addr), .iWData(wdata),
    .oReady(ready), .oValid(valid), .oRData(rdata), .oFault(fault), .oMemSel(memSel),
    .oMemAddr(memAddr), .oMemWren(wren), .oMemBE(memBE), .oMemWData(memWData), .iMemRData(memQ));

  code_memory_controller #(.MEM_LATENCY(3)) dut3 (
    .iCLK(clk), .iRST(rstN), .iReq(req3), .iWe(1'b0), .iBE(4'h0), .iAddr(addr3), .iWData(32'h0),
    .oReady(ready3), .oValid(valid3), .oRData(rdata3), .oFault(fault3), .oMemSel(sel3),
    .oMemAddr(maddr3), .oMemWren(wren3), .oMemBE(be3), .oMemWData(wd3), .iMemRData(q3c));

  function automatic logic [31:0] memWord(input int i, input logic [29:0] a);
    if (i == 1 && a == 30'd4) return 32'hDEAD_BEEF;
    return {4'hC, 4'(i), a[23:0]};
  endfunction

  // Unselected blocks return garbage so an early capture shows up as wrong data.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      memQ[i*32 +: 32] <= memSel[i] ? memWord(i, memAddr) : 32'hBAD0_BAD0;
      q3a[i*32 +: 32]  <= sel3[i] ? memWord(i, maddr3) : 32'hBAD0_BAD0;
    end
    q3b <= q3a;
    q3c <= q3b;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nTests = 0;
  int nFail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        fault;
  } resp_t;
  resp_t sb[$];

  always @(negedge clk) begin
    if (rstN && valid) begin
      if (sb.size() == 0) begin
        nTests++;
        nFail++;
        $display("FAIL unexpected_valid: got oValid=1 at cycle %0d, expected none", cyc);
      end else begin
        resp_t e;
        e = sb.pop_front();
        check("valid_cycle", cyc, e.cyc);
        check("rdata", rdata, e.data);
        check("fault", {31'b0, fault}, {31'b0, e.fault});
      end
    end
  end

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        fault;
    logic [31:0] rdata;
    int          lat;
    logic [2:0]  sel;
    logic [29:0] maddr;
  } vec_t;

  task automatic doReq(input vec_t v, input int idx);
    int n;
    logic expWren;
    we = v.we; be = v.be; addr = v.addr; wdata = v.wdata; req = 1'b1;
    n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      nTests++;
      nFail++;
      $display("FAIL accept_timeout[%0d]: got oReady=0 for %0d cycles, expected 1", idx, n);
      req = 1'b0;
      return;
    end
    sb.push_back('{cyc + 1 + v.lat, v.rdata, v.fault});
    @(negedge clk);
    req = 1'b0;
    expWren = v.we && !v.fault;
    check($sformatf("mem_sel[%0d]", idx), {29'b0, memSel}, {29'b0, v.sel});
    check($sformatf("mem_addr[%0d]", idx), {2'b0, memAddr}, {2'b0, v.maddr});
    check($sformatf("mem_wren[%0d]", idx), {31'b0, wren}, {31'b0, expWren});
    if (expWren) begin
      check($sformatf("mem_be[%0d]", idx), {28'b0, memBE}, {28'b0, v.be});
      check($sformatf("mem_wdata[%0d]", idx), memWData, v.wdata);
    end
    @(negedge clk);
    check($sformatf("wren_one_cycle[%0d]", idx), {31'b0, wren}, 32'd0);
  endtask

  vec_t tv[15];

  initial begin
    int c, n;
    tv[0]  = '{1'b0, 4'h0, 32'h0040_0010, 32'h0,          1'b0, 32'hDEAD_BEEF,        2, 3'b010, 30'd4};
    tv[1]  = '{1'b1, 4'h3, 32'h8000_0004, 32'h1234_5678,  1'b0, 32'h0,                1, 3'b100, 30'd1};
    tv[2]  = '{1'b1, 4'hF, 32'h0000_0000, 32'hFFFF_FFFF,  1'b1, 32'h0,                0, 3'b000, 30'd0};
    tv[3]  = '{1'b0, 4'h0, 32'h0040_4000, 32'h0,          1'b1, 32'h0,                0, 3'b000, 30'd0};
    tv[4]  = '{1'b0, 4'h0, 32'h0000_07FC, 32'h0,          1'b0, memWord(0, 30'h1FF),  2, 3'b001, 30'h1FF};
    tv[5]  = '{1'b0, 4'h0, 32'h0000_0800, 32'h0,          1'b1, 32'h0,                0, 3'b000, 30'd0};
    tv[6]  = '{1'b0, 4'h0, 32'h8000_1FFC, 32'h0,          1'b0, memWord(2, 30'h7FF),  2, 3'b100, 30'h7FF};
    tv[7]  = '{1'b1, 4'hF, 32'h0040_3FFC, 32'hA5A5_5A5A,  1'b0, 32'h0,                1, 3'b010, 30'hFFF};
    tv[8]  = '{1'b0, 4'h0, 32'h8000_2000, 32'h0,          1'b1, 32'h0,                0, 3'b000, 30'd0};
    tv[9]  = '{1'b1, 4'hF, 32'h7FFF_FFFC, 32'h0BAD_0BAD,  1'b1, 32'h0,                0, 3'b000, 30'd0};
    tv[10] = '{1'b0, 4'h0, 32'h0040_0000, 32'h0,          1'b0, memWord(1, 30'd0),    2, 3'b010, 30'd0};
    tv[11] = '{1'b0, 4'h0, 32'h0040_0004, 32'h0,          1'b0, memWord(1, 30'd1),
               PF ? 0 : 2, PF ? 3'b000 : 3'b010, PF ? 30'd0 : 30'd1};
    tv[12] = '{1'b1, 4'h1, 32'h0040_0008, 32'h0000_00EE,  1'b0, 32'h0,                1, 3'b010, 30'd2};
    tv[13] = '{1'b0, 4'h0, 32'h0040_0008, 32'h0,          1'b0, memWord(1, 30'd2),    2, 3'b010, 30'd2};
    tv[14] = '{1'b0, 4'h0, 32'h0040_0013, 32'h0,          1'b0, 32'hDEAD_BEEF,        2, 3'b010, 30'd4};

    rstN = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
    req3 = 1'b0; addr3 = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    check("rst_wren", {31'b0, wren}, 32'd0);
    check("rst_sel", {29'b0, memSel}, 32'd0);
    check("rst_maddr", {2'b0, memAddr}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_be_wdata", {28'b0, memBE} | memWData, 32'd0);
    check("rst_ready3", {31'b0, ready3}, 32'd1);
    rstN = 1'b1;

    for (int i = 0; i < 15; i++) doReq(tv[i], i);

    n = 0;
    while ((sb.size() != 0 || !ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_before_midreset", sb.size(), 32'd0);

    // Reset during WAIT must drop the read silently.
    addr = 32'h0040_0010; we = 1'b0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("midrst_sel_in_wait", {29'b0, memSel}, 32'd2);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    check("midrst_ready", {31'b0, ready}, 32'd1);
    check("midrst_valid", {31'b0, valid}, 32'd0);
    check("midrst_sel", {29'b0, memSel}, 32'd0);
    check("midrst_maddr", {2'b0, memAddr}, 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    check("midrst_fault_wren", {30'b0, fault, wren}, 32'd0);
    repeat (4) @(negedge clk);

    // Three-cycle-latency instance: top word of the boot region.
    addr3 = 32'h0000_07FC; req3 = 1'b1;
    check("l3_ready", {31'b0, ready3}, 32'd1);
    c = cyc;
    @(negedge clk);
    req3 = 1'b0;
    check("l3_sel", {29'b0, sel3}, 32'd1);
    check("l3_maddr", {2'b0, maddr3}, 32'h1FF);
    n = 0;
    while (!valid3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("l3_valid_cycle", cyc, c + 1 + 4);
    check("l3_rdata", rdata3, memWord(0, 30'h1FF));
    check("l3_fault", {31'b0, fault3}, 32'd0);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test by 500000, expected earlier finish");
    $fatal(1, "watchdog expired");
  end
endmodule
